// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 (even parity bit after bit 7)
module uart_tx #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST = 16'(CLK_FREQ / BAUD_RATE - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [7:0] shift;
  logic [15:0] cnt;
  logic [2:0] bidx, bidx_n;
  logic last, have, push, pop, tx_n;
  assign tx_ready = fifo_count != FULL;
  assign last = cnt == LAST;
  assign have = fifo_count != '0;
  assign push = tx_valid && tx_ready;
  assign pop = have && (state == IDLE || (state == STOP && last));
  assign bidx_n = pop ? 3'd0 : (state == DATA && last) ? bidx + 3'd1 : bidx;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = pop ? START : IDLE;
      START:  state_n = last ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:   state_n = (last && bidx == 3'd7) ? PARITY : DATA;
      PARITY: state_n = last ? STOP : PARITY;
`else
      DATA:   state_n = (last && bidx == 3'd7) ? STOP : DATA;
`endif
      STOP:   state_n = last ? (pop ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
  end
  // line level is computed for the upcoming cycle so tx can be registered
  always_comb begin
    tx_n = 1'b1;
    if (state_n == START) tx_n = 1'b0;
    else if (state_n == DATA) tx_n = shift[bidx_n];
`ifdef UART_TX_PARITY_EN
    else if (state_n == PARITY) tx_n = ^shift;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      fifo_count <= '0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      bidx       <= '0;
    end else begin
      state      <= state_n;
      tx         <= tx_n;
      tx_busy    <= state_n != IDLE;
      cnt        <= (state == IDLE || last) ? '0 : cnt + 16'd1;
      bidx       <= bidx_n;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wp] <= tx_data;
    if (!rst && pop) shift <= mem[rp];
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table, directed frame sequences and a random run against a frame-level model
module tb_uart_tx;
  localparam int CPB = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = NB * CPB;
  logic clk = 1'b0, rst = 1'b1, tx_valid = 1'b1;
  logic [7:0] tx_data = 8'hFF;
  logic tx, tx_ready, tx_busy;
  logic [2:0] fifo_count;
  int ntot = 0, npass = 0;
  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  // frame bit i of byte b: start, 8 data LSB first, optional even parity, stop
  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PAR && i == 9) return ^b;
    return 1'b1;
  endfunction
  logic [7:0] q[$];
  logic [7:0] mcur = 8'h00;
  int t = 0;
  bit mbusy = 1'b0, men = 1'b0, mhave, mrdy;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      mbusy = 1'b0;
      t = 0;
      men = 1'b1;
    end else begin
      mhave = q.size() != 0;
      mrdy = q.size() != DEPTH;
      if (mbusy && t == FL - 1) begin
        if (mhave) begin
          mcur = q.pop_front();
          t = 0;
        end else mbusy = 1'b0;
      end else if (mbusy) t++;
      else if (mhave) begin
        mcur = q.pop_front();
        mbusy = 1'b1;
        t = 0;
      end
      if (tx_valid && mrdy) q.push_back(tx_data);
    end
  end
  always @(negedge clk)
    if (men) chk("line", {tx, tx_busy, fifo_count, tx_ready},
                 {mbusy ? fbit(mcur, t / CPB) : 1'b1, mbusy, 3'(q.size()), q.size() != DEPTH});
  int run = 0, last_run = 0;
  always @(negedge clk) begin
    if (tx_busy === 1'b1) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end
  task automatic push(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data = d;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    while (tx_busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < bound), 32'd1);
  endtask
  // call at or before the negedge of a frame's first start cycle; returns at its last stop cycle
  task automatic rx_byte(output logic [7:0] b, output logic p, output logic s);
    int n = 0;
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_start_timeout", 32'(n < 2000), 32'd1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = tx;
    end
    repeat (10) @(negedge clk);
    p = tx;
    s = tx;
    if (PAR) begin
      repeat (10) @(negedge clk);
      s = tx;
    end
    repeat (4) @(negedge clk);
  endtask
  typedef struct {
    logic r; logic v; logic [7:0] d;
    logic etx; logic ebusy; logic [2:0] ecnt; logic erdy;
  } vec_t;
  vec_t vt[7];
  int at[7];
  logic [7:0] b;
  logic p, s, acc, lowseen;
  initial begin
    vt = '{
      '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1},
      '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1},
      '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1},
      '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1},
      '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1},
      '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 3'd1, 1'b1},
      '{1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 3'd0, 1'b1}
    };
    for (int i = 0; i < 7; i++) begin
      rst = vt[i].r;
      tx_valid = vt[i].v;
      tx_data = vt[i].d;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_tx", i), 32'(tx), 32'(vt[i].etx));
      chk($sformatf("vec%0d_busy", i), 32'(tx_busy), 32'(vt[i].ebusy));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].ecnt));
      chk($sformatf("vec%0d_ready", i), 32'(tx_ready), 32'(vt[i].erdy));
    end
    rx_byte(b, p, s);
    chk("b55_data", 32'(b), 32'h55);
    chk("b55_stop", 32'(s), 32'd1);
    repeat (2) @(negedge clk);
    chk("b55_busy_after", 32'(tx_busy), 32'd0);
    chk("b55_frame_len", 32'(last_run), 32'(FL));
    begin
      int d = 1, c = 0;
      while (d <= 6 && c < 400) begin
        tx_valid = 1'b1;
        tx_data = 8'(d);
        acc = tx_ready;
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
          at[d] = c;
          d++;
        end
        c++;
      end
      tx_valid = 1'b0;
      chk("fill_all_accepted", 32'(d), 32'd7);
    end
    for (int i = 1; i <= 5; i++) chk($sformatf("fill_accept_edge%0d", i), 32'(at[i]), 32'(i - 1));
    chk("fill_accept_edge6", 32'(at[6]), 32'(FL + 2));
    wait_idle(7 * FL);
    repeat (2) @(negedge clk);
    chk("fill_b2b_len", 32'(last_run), 32'(6 * FL));
    push(8'hA5);
    push(8'hB1);
    push(8'hC2);
    chk("rstmid_queued", 32'(fifo_count), 32'd2);
    repeat (41) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_tx", 32'(tx), 32'd1);
    chk("rstmid_count", 32'(fifo_count), 32'd0);
    chk("rstmid_busy", 32'(tx_busy), 32'd0);
    lowseen = 1'b0;
    repeat (3 * FL) begin
      @(negedge clk);
      if (tx !== 1'b1) lowseen = 1'b1;
    end
    chk("rstmid_line_quiet", 32'(lowseen), 32'd0);
    push(8'h3C);
    push(8'h5A);
    push(8'h96);
    repeat (FL - 2) @(negedge clk);
    chk("pushpop_before", 32'(fifo_count), 32'd2);
    push(8'hE7);
    chk("pushpop_after", 32'(fifo_count), 32'd2);
    rx_byte(b, p, s);
    chk("pushpop_order0", 32'(b), 32'h5A);
    rx_byte(b, p, s);
    chk("pushpop_order1", 32'(b), 32'h96);
    rx_byte(b, p, s);
    chk("pushpop_order2", 32'(b), 32'hE7);
    wait_idle(2 * FL);
    push(8'h07);
    push(8'h03);
    rx_byte(b, p, s);
    chk("par07_data", 32'(b), 32'h07);
    chk("par07_bit", 32'(p), 32'(PAR ? 1'b1 : 1'b1));
    rx_byte(b, p, s);
    chk("par03_data", 32'(b), 32'h03);
    chk("par03_bit", 32'(p), 32'(PAR ? 1'b0 : 1'b1));
    chk("par03_stop", 32'(s), 32'd1);
    wait_idle(2 * FL);
    repeat (2) @(negedge clk);
    chk("par_two_frame_len", 32'(last_run), 32'(2 * FL));
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 599) == 0;
      tx_valid = $urandom_range(0, 2) == 0;
      tx_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    tx_valid = 1'b0;
    wait_idle(6 * FL);
    chk("rand_drained", 32'(fifo_count), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, ntot);
    $fatal(1);
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter, the transmit-side counterpart of the board's UART receive path toward the host link. It accepts bytes through a valid/ready handshake into a small FIFO and serialises each one onto `tx`: idle-high line, LSB first, one start bit, eight data bits, one stop bit, with an optional even-parity bit. It sits between the health-monitor logic that produces report bytes and the FPGA TX pin.

## Interface
- `CLK_FREQ`, 25_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` uses integer division, giving 2604 at the defaults. The legal range is 2..65535.
- `FIFO_DEPTH`, 4: number of FIFO entries. It must be a power of two and at least 2.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte. Combinational: `fifo_count != FIFO_DEPTH`.
- `tx`  out  1  serial line, registered.
- `tx_busy`  out  1  a frame is in progress (state != IDLE), registered.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued bytes.

## Operation
- **Write:** a byte is pushed into the FIFO on a rising edge where `tx_valid && tx_ready && !rst`. There is no bypass: when the FIFO is full, `tx_ready` stays 0 even if a pop happens in the same cycle.
- **Simultaneous push and pop:** `fifo_count` is unchanged and the data ordering is preserved.
- **FIFO pointers:** the read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- **State machine:** IDLE, START, DATA, PARITY (only when the parity feature is compiled in), STOP.
  - IDLE: `tx`=1. If `fifo_count`>0, pop the FIFO head into the shift register, clear the bit counter and the bit index, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=`shift[bit_index]`, with bit 0 first. Each bit is held `CLKS_PER_BIT` cycles. After bit 7, go to PARITY if enabled, otherwise to STOP.
  - PARITY: `tx` = XOR of all 8 data bits for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the last cycle, if `fifo_count`>0, pop and go directly to START (back-to-back). Otherwise go to IDLE.
- **Bit counter:** 16 bits. It counts 0..`CLKS_PER_BIT`-1 and resets to 0 on every bit boundary.
- **Reset values:** `tx`=1, `tx_busy`=0, `fifo_count`=0, and therefore `tx_ready`=1 after reset. Also state=IDLE, counters 0.
- **Reset while `rst`=1:** writes are ignored.
- **Reset mid-frame:** the frame is aborted. `tx` returns to 1 at that edge, queued bytes are discarded, and no partial stop bit is emitted.

## Timing
- **Start latency:** if a write is accepted at edge k while IDLE with the FIFO empty, the pop occurs at edge k+1 and `tx` is low from edge k+1.
- **Frame length:** 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- **Back-to-back frames:** the next start bit begins on the cycle right after the last stop-bit cycle, with zero idle cycles between frames.
- **`tx_busy`:** rises at the pop edge. It falls at the edge after the final stop cycle only if the FIFO is empty.
- **`fifo_count`:** decrements at the pop edge.
- **`tx_ready`:** rises in the same cycle as that `fifo_count` update.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state is present and an even-parity bit is inserted between bit 7 and stop (8E1, 11 bit times per frame).
- **Undefined:** the PARITY state and its logic are absent; the format is 8N1, 10 bit times per frame.

## Test plan
All scenarios use `CLK_FREQ`=1_000_000 and `BAUD_RATE`=100_000, so `CLKS_PER_BIT`=10, with `FIFO_DEPTH`=4.
- **Reset:** hold `rst`=1 for 3 cycles with `tx_valid`=1 and `tx_data`=0xFF. Required: `tx`=1, `tx_busy`=0, `fifo_count`=0, `tx_ready`=1, and no frame is sent after reset deasserts with `tx_valid`=0.
- **Single byte 0x55:** `tx` goes low one cycle after acceptance. The line then reads 0, then data 1,0,1,0,1,0,1,0 (LSB first), then 1, with each level lasting 10 cycles. The frame is 100 cycles long, and `tx_busy` falls immediately after it.
- **FIFO fill, full and back-to-back:** hold `tx_valid`=1 and advance the data on every accepted write through 0x01..0x06.
  - 0x01..0x05 are accepted on 5 consecutive edges; 0x01 is popped at the second edge.
  - `fifo_count` then reaches 4 and `tx_ready`=0 until the end of the 0x01 stop bit.
  - 0x06 is accepted on the cycle after that pop.
  - All six frames are emitted contiguously (600 cycles) with no idle cycles.
- **Reset mid-frame:** while sending 0xA5 with 2 bytes queued, pulse `rst` for 1 cycle during data bit 3. Required: `tx`=1 and `fifo_count`=0 at that edge, and `tx` stays 1 with no further frames.
- **Simultaneous push and pop:** with `fifo_count`=2, issue a write on the STOP-end pop cycle. Required: `fifo_count` stays 2 and the byte order is preserved.
- **Parity (macro defined):** 0x07 produces parity bit 1 and 0x03 produces parity bit 0, each frame 110 cycles. Without the macro, the same bytes give 100-cycle frames with no parity bit.
